// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and limits for the iterative multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mult_state_t;

    // Smallest operand width for which the shift datapath is well formed.
    localparam int MULT_MIN_N = 2;

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one combinational shift-add / radix-2 Booth iteration
module mult_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] q,
    input  logic         qm1,
    input  logic         carry,
    input  logic [N-1:0] m,
    input  logic         mode,
    output logic [N-1:0] acc_next,
    output logic [N-1:0] q_next,
    output logic         qm1_next,
    output logic         carry_next
);

    localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

    logic [N:0] sum;

    // Add/subtract at N+1 bits, then shift the extended sum down into {A,Q}.
    // In signed mode sum[N] is the true sign, so -2^(N-1) * -2^(N-1) survives.
    always_comb begin
        sum = {carry, acc};
        if (mode) begin
            unique case ({q[0], qm1})
                2'b01:   sum = {acc[N-1], acc} + {m[N-1], m};
                2'b10:   sum = {acc[N-1], acc} + ~{m[N-1], m} + ONE;
                default: sum = {acc[N-1], acc};
            endcase
        end else if (q[0]) begin
            sum = {1'b0, acc} + {1'b0, m};
        end
        acc_next   = sum[N:1];
        q_next     = {sum[0], q[N-1:1]};
        qm1_next   = q[0];
        carry_next = 1'b0;
    end

endmodule

// File: rtl/seq_mult_signed.sv
// rtl/seq_mult_signed.sv - iterative signed/unsigned multiplier; MULT_OVF_EN adds overflow output
module seq_mult_signed
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
`ifdef MULT_OVF_EN
    ,
    output logic           overflow
`endif
);

    localparam int CW = $clog2(N + 1);

    if (N < MULT_MIN_N) begin : g_n_check
        $error("seq_mult_signed: N must be at least %0d", MULT_MIN_N);
    end

    mult_state_t    state, state_next;
    logic [N-1:0]   acc, q, m_reg;
    logic           qm1, carry, mode;
    logic [CW-1:0]  count;

    logic [N-1:0]   acc_step, q_step;
    logic           qm1_step, carry_step;
    logic           last_step;
    logic [2*N-1:0] result;

    mult_step #(.N(N)) u_step (
        .acc        (acc),
        .q          (q),
        .qm1        (qm1),
        .carry      (carry),
        .m          (m_reg),
        .mode       (mode),
        .acc_next   (acc_step),
        .q_next     (q_step),
        .qm1_next   (qm1_step),
        .carry_next (carry_step)
    );

    assign last_step = (state == CALC) && (count == CW'(1));
    assign result    = {acc_step, q_step};

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = CALC;
            end
            CALC: begin
                if (count == CW'(1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on accepted start, one iteration per CALC cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            q     <= '0;
            m_reg <= '0;
            qm1   <= 1'b0;
            carry <= 1'b0;
            mode  <= 1'b0;
            count <= '0;
        end else if (state == IDLE && start) begin
            acc   <= '0;
            q     <= b;
            m_reg <= a;
            qm1   <= 1'b0;
            carry <= 1'b0;
            mode  <= signed_mode;
            count <= CW'(N);
        end else if (state == CALC) begin
            acc   <= acc_step;
            q     <= q_step;
            qm1   <= qm1_step;
            carry <= carry_step;
            count <= count - CW'(1);
        end
    end

    // Result register: loaded from the final iteration so it is valid with done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          product <= '0;
        else if (last_step) product <= result;
    end

`ifdef MULT_OVF_EN
    logic [N:0] upper_signed;
    logic       ovf_calc;

    assign upper_signed = result[2*N-1:N-1];
    assign ovf_calc     = mode ? !((upper_signed == '0) || (&upper_signed))
                               : (|result[2*N-1:N]);

    // Overflow flag follows the product, and is cleared when a new start is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                      overflow <= 1'b0;
        else if (state == IDLE && start) overflow <= 1'b0;
        else if (last_step)             overflow <= ovf_calc;
    end
`endif

endmodule

// File: tb/tb_seq_mult_signed.sv
// tb/tb_seq_mult_signed.sv - scoreboard bench for seq_mult_signed at N=8 and N=13
module tb_seq_mult_signed;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        start8, mode8, ready8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;
    logic        start13, mode13, ready13, done13;
    logic [12:0] a13, b13;
    logic [25:0] prod13;
`ifdef MULT_OVF_EN
    logic        ovf8, ovf13;
`endif

    seq_mult_signed #(.N(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .signed_mode(mode8),
        .a(a8), .b(b8), .ready(ready8), .done(done8), .product(prod8)
`ifdef MULT_OVF_EN
        , .overflow(ovf8)
`endif
    );

    seq_mult_signed #(.N(13)) dut13 (
        .clock(clock), .reset(reset), .start(start13), .signed_mode(mode13),
        .a(a13), .b(b13), .ready(ready13), .done(done13), .product(prod13)
`ifdef MULT_OVF_EN
        , .overflow(ovf13)
`endif
    );

    typedef struct {
        logic [63:0] prod;
        bit          ovf;
    } exp_t;

    exp_t   sb8[$];
    exp_t   sb13[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint last_done8 = -1;
    bit     cont8 = 1'b0;
    int     ndone8 = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer product of the operands as interpreted by the mode.
    function automatic exp_t model(input int n, input bit sm, input logic [63:0] ua, input logic [63:0] ub);
        longint sa, sbv, p;
        exp_t   e;
        sa  = longint'(ua);
        sbv = longint'(ub);
        if (sm && ua[n-1]) sa  = sa  - (longint'(1) << n);
        if (sm && ub[n-1]) sbv = sbv - (longint'(1) << n);
        p = sa * sbv;
        if (sm) e.ovf = (p < -(longint'(1) << (n-1))) || (p >= (longint'(1) << (n-1)));
        else    e.ovf = (p >= (longint'(1) << n));
        e.prod = 64'(p & ((longint'(1) << (2*n)) - 1));
        return e;
    endfunction

    function automatic logic [63:0] pick(input int n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'd1 << (n-1);
            3:       return 64'd1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    task automatic drive8(input bit s, input bit m, input logic [7:0] x, input logic [7:0] y);
        start8 = s; mode8 = m; a8 = x; b8 = y;
        if (s && ready8) sb8.push_back(model(8, m, 64'(x), 64'(y)));
    endtask

    task automatic drive13(input bit s, input bit m, input logic [12:0] x, input logic [12:0] y);
        start13 = s; mode13 = m; a13 = x; b13 = y;
        if (s && ready13) sb13.push_back(model(13, m, 64'(x), 64'(y)));
    endtask

    // Monitors: pop the oldest expectation whenever a DUT presents done.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && done8 === 1'b1) begin
            ndone8++;
            if (sb8.size() == 0) begin
                check("done8_unexpected", 64'(done8), 64'd0);
            end else begin
                e = sb8.pop_front();
                check("prod8", 64'(prod8), e.prod);
`ifdef MULT_OVF_EN
                check("ovf8", 64'(ovf8), 64'(e.ovf));
`endif
            end
            if (cont8 && last_done8 >= 0) check("interval8", 64'(cyc - last_done8), 64'd10);
            last_done8 = cyc;
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && done13 === 1'b1) begin
            if (sb13.size() == 0) begin
                check("done13_unexpected", 64'(done13), 64'd0);
            end else begin
                e = sb13.pop_front();
                check("prod13", 64'(prod13), e.prod);
`ifdef MULT_OVF_EN
                check("ovf13", 64'(ovf13), 64'(e.ovf));
`endif
            end
        end
    end

    task automatic run8(input bit m, input logic [7:0] x, input logic [7:0] y,
                        output logic [15:0] p, output logic o);
        int t;
        t = 0;
        @(negedge clock);
        while (ready8 !== 1'b1 && t < 30) begin @(negedge clock); t++; end
        drive8(1'b1, m, x, y);
        @(posedge clock); #1 start8 = 1'b0;
`ifdef MULT_OVF_EN
        check("ovf_clear_on_start", 64'(ovf8), 64'd0);
`endif
        t = 0;
        while (done8 !== 1'b1 && t < 30) begin @(posedge clock); #1; t++; end
        check("run8_done", 64'(done8), 64'd1);
        p = prod8;
`ifdef MULT_OVF_EN
        o = ovf8;
`else
        o = 1'b0;
`endif
    endtask

    initial begin
        logic [15:0] p;
        logic        o;
        bit          early;
        int          t, n0;

        reset = 1'b1;
        drive8(1'b0, 1'b0, 8'd0, 8'd0);
        drive13(1'b0, 1'b0, 13'd0, 13'd0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready8", 64'(ready8), 64'd1);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_prod8", 64'(prod8), 64'd0);
        check("rst_ready13", 64'(ready13), 64'd1);
        check("rst_prod13", 64'(prod13), 64'd0);
`ifdef MULT_OVF_EN
        check("rst_ovf8", 64'(ovf8), 64'd0);
`endif
        @(negedge clock) reset = 1'b0;

        // 255*255 unsigned with exact latency
        @(negedge clock) drive8(1'b1, 1'b0, 8'd255, 8'd255);
        @(posedge clock); #1 start8 = 1'b0;
        early = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clock); #1;
            if (j < 8 && done8 !== 1'b0) early = 1'b1;
        end
        check("done_early", 64'(early), 64'd0);
        check("done_latency", 64'(done8), 64'd1);
        check("prod_255x255", 64'(prod8), 64'hFE01);
        @(posedge clock); #1;
        check("ready_after_done", 64'(ready8), 64'd1);
        check("done_one_cycle", 64'(done8), 64'd0);

        run8(1'b1, 8'h80, 8'h80, p, o);
        check("prod_m128xm128", 64'(p), 64'h4000);
        run8(1'b1, 8'hFD, 8'h05, p, o);
        check("prod_m3x5", 64'(p), 64'hFFF1);

        // reset four cycles into CALC
        @(negedge clock) drive8(1'b1, 1'b0, 8'd200, 8'd100);
        @(posedge clock); #1 start8 = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        sb8.delete();
        sb13.delete();
        #1;
        check("rst_mid_ready", 64'(ready8), 64'd1);
        check("rst_mid_prod", 64'(prod8), 64'd0);
        n0 = ndone8;
        @(negedge clock) reset = 1'b0;
        repeat (15) @(negedge clock);
        check("rst_mid_no_done", 64'(ndone8 - n0), 64'd0);
        run8(1'b0, 8'd7, 8'd6, p, o);
        check("prod_7x6", 64'(p), 64'd42);

`ifdef MULT_OVF_EN
        run8(1'b0, 8'd16, 8'd16, p, o);
        check("ovf_16x16_prod", 64'(p), 64'd256);
        check("ovf_16x16", 64'(o), 64'd1);
        run8(1'b0, 8'd15, 8'd17, p, o);
        check("ovf_15x17_prod", 64'(p), 64'd255);
        check("ovf_15x17", 64'(o), 64'd0);
        run8(1'b1, 8'd3, 8'hFB, p, o);
        check("ovf_3xm5", 64'(o), 64'd0);
        run8(1'b1, 8'h80, 8'hFF, p, o);
        check("ovf_m128xm1_prod", 64'(p), 64'h0080);
        check("ovf_m128xm1", 64'(o), 64'd1);
`endif

        // start held high with changing operands
        @(negedge clock);
        while (ready8 !== 1'b1) @(negedge clock);
        cont8 = 1'b1;
        last_done8 = -1;
        for (int j = 0; j < 60; j++) begin
            drive8(1'b1, j[0], 8'($urandom), 8'($urandom));
            @(negedge clock);
        end
        start8 = 1'b0;
        t = 0;
        while (sb8.size() != 0 && t < 40) begin @(negedge clock); t++; end
        cont8 = 1'b0;

        // randomized, both widths in parallel
        fork
            begin : rnd8
                int c0, c1, g;
                bit m, s;
                logic [63:0] x, y;
                c0 = 0; c1 = 0; g = 0;
                while ((c0 < 1000 || c1 < 1000) && g < 45000) begin
                    @(negedge clock);
                    g++;
                    m = bit'($urandom_range(0, 1));
                    if (m && c1 >= 1000) m = 1'b0;
                    if (!m && c0 >= 1000) m = 1'b1;
                    s = ($urandom_range(0, 3) != 0);
                    if (s && ready8) begin
                        if (m) c1++;
                        else   c0++;
                    end
                    x = pick(8);
                    y = pick(8);
                    drive8(s, m, x[7:0], y[7:0]);
                end
                check("rnd8_count", 64'(c0 + c1), 64'd2000);
                @(negedge clock) start8 = 1'b0;
            end
            begin : rnd13
                int c0, c1, g;
                bit m, s;
                logic [63:0] x, y;
                c0 = 0; c1 = 0; g = 0;
                while ((c0 < 1000 || c1 < 1000) && g < 60000) begin
                    @(negedge clock);
                    g++;
                    m = bit'($urandom_range(0, 1));
                    if (m && c1 >= 1000) m = 1'b0;
                    if (!m && c0 >= 1000) m = 1'b1;
                    s = ($urandom_range(0, 3) != 0);
                    if (s && ready13) begin
                        if (m) c1++;
                        else   c0++;
                    end
                    x = pick(13);
                    y = pick(13);
                    drive13(s, m, x[12:0], y[12:0]);
                end
                check("rnd13_count", 64'(c0 + c1), 64'd2000);
                @(negedge clock) start13 = 1'b0;
            end
        join

        t = 0;
        while ((sb8.size() != 0 || sb13.size() != 0) && t < 200) begin @(negedge clock); t++; end
        check("sb8_drained", 64'(sb8.size()), 64'd0);
        check("sb13_drained", 64'(sb13.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
